// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// The CHK state exists only when LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int HDR_W      = 32;

    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CHK     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes big-endian into 32-bit words.
// word_next_o/last_byte_o show the word completing this cycle; word_valid_o/word_o follow one cycle later.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic        emit_i,
    output logic        last_byte_o,
    output logic [31:0] word_next_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  cnt_q;
    logic [31:0] sr_q;
    logic        vld_q;

    assign last_byte_o  = byte_valid_i && (cnt_q == LAST_IDX);
    assign word_next_o  = {sr_q[23:0], byte_i};
    assign word_valid_o = vld_q;
    assign word_o       = sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            sr_q  <= 32'd0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= last_byte_o && emit_i;
            if (byte_valid_i) begin
                cnt_q <= cnt_q + 2'd1;
                sr_q  <= word_next_o;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: header word N, then N words, then releases the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing checksum word before release.
//
// state   | meaning
// HDR     | collecting the 4-byte word count
// LOAD    | collecting program words, one write per word
// CHK     | collecting the checksum word (checksum build only)
// RELEASE | one-cycle settle, CPU still held
// RUN     | CPU released, load done
// ERR     | load failed, CPU held
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_start_up,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    import imem_loader_pkg::*;

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic              rdy_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   cnt_q;
    logic              byte_fire;
    logic              last_byte;
    logic [HDR_W-1:0]  word_next;
    logic              word_valid;
    logic [31:0]       word;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       sum_q;
`endif

    assign byte_fire = in_valid && in_ready;

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid_i (byte_fire),
        .byte_i       (in_data),
        .emit_i       (state_q == ST_LOAD),
        .last_byte_o  (last_byte),
        .word_next_o  (word_next),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        cpu_start_up = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (state_q)
            ST_HDR: begin
                in_ready = rdy_q;
                if (last_byte) begin
                    if (word_next == '0)
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_RELEASE;
`endif
                    else if (word_next > 32'(DEPTH))
                        state_d = ST_ERR;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = rdy_q;
                if (word_valid && (cnt_q + ONE == n_q))
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_RELEASE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                in_ready = rdy_q;
                if (last_byte)
                    state_d = (sum_q + word_next == 32'd0) ? ST_RELEASE : ST_ERR;
            end
`endif
            ST_RELEASE: state_d = ST_RUN;
            ST_RUN: begin
                cpu_start_up = 1'b0;
                done         = 1'b1;
            end
            ST_ERR: error = 1'b1;
            default: state_d = ST_ERR;
        endcase
    end

    // Header capture and per-word counting; the header word never produces word_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR;
            rdy_q   <= 1'b0;
            n_q     <= '0;
            cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (state_q == ST_HDR && last_byte)
                n_q <= word_next[ADDR_W:0];
            if (word_valid)
                cnt_q <= cnt_q + ONE;
`ifdef LOADER_CHECKSUM_EN
            if (state_q == ST_HDR && last_byte)
                sum_q <= word_next;
            else if (word_valid)
                sum_q <= sum_q + word;
`endif
        end
    end

    assign imem_we      = word_valid;
    assign imem_addr    = cnt_q[ADDR_W-1:0];
    assign imem_wdata   = word;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; checksum cases run when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready, imem_we, cpu_start_up, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_start_up (cpu_start_up),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    wr_t         exp_q[$];
    wr_t         got_w;
    logic [31:0] words_q[$];
    int          acc4[DEPTH];
    int          last_we_cyc  = 0;
    int          done_cyc     = 0;
    int          last_acc_cyc = 0;
    bit          done_seen    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every write must match the next expected (address, word) and land one cycle after its 4th byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we) begin
                last_we_cyc = cyc;
                check("write_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) begin
                    got_w = exp_q.pop_front();
                    check("write_addr", 32'(imem_addr), 32'(got_w.addr));
                    check("write_data", imem_wdata, got_w.data);
                    check("write_cycle", 32'(cyc), 32'(acc4[got_w.addr] + 1));
                end
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int acc_cyc;
        acc = 1'b0;
        acc_cyc = 0;
        if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc     = in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("byte_accept_timeout", {31'd0, acc}, 32'd1);
        last_acc_cyc = acc_cyc;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, input int idx);
        for (int b = 0; b < 4; b++)
            send_byte(w[31 - 8*b -: 8], gaps);
        if (idx >= 0) acc4[idx] = last_acc_cyc;
    endtask

    function automatic logic [31:0] ck_for(input logic [31:0] n);
        logic [31:0] s;
        s = n;
        foreach (words_q[i]) s = s + words_q[i];
        return 32'd0 - s;
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_start_up", {31'd0, cpu_start_up}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Model: header N, N words from words_q, optional checksum word; outcome from plain arithmetic.
    task automatic do_load(input logic [31:0] n, input logic [31:0] ck, input bit gaps);
        logic [31:0] sum;
        bit          ok;
        int          exp_cnt;
        wr_t         e;
        exp_q.delete();
        done_seen = 1'b0;
        sum = n;
        ok  = (n <= 32'(DEPTH));
        if (ok) begin
            for (int i = 0; i < int'(n); i++) begin
                e.addr = i;
                e.data = words_q[i];
                exp_q.push_back(e);
                sum = sum + words_q[i];
            end
        end
        exp_cnt = ok ? int'(n) : 0;
`ifdef LOADER_CHECKSUM_EN
        if (ok) ok = (sum + ck == 32'd0);
`endif
        send_word(n, gaps, -1);
        if (n <= 32'(DEPTH)) begin
            for (int i = 0; i < int'(n); i++) send_word(words_q[i], gaps, i);
`ifdef LOADER_CHECKSUM_EN
            send_word(ck, gaps, -1);
`endif
        end
        in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done || error) break;
        end
        @(negedge clk);
        #1;
        check("load_finished", {31'd0, done | error}, 32'd1);
        check("done", {31'd0, done}, {31'd0, ok});
        check("error", {31'd0, error}, {31'd0, ~ok});
        check("cpu_start_up", {31'd0, cpu_start_up}, {31'd0, ~ok});
        check("in_ready_final", {31'd0, in_ready}, 32'd0);
        check("words_loaded", 32'(words_loaded), 32'(exp_cnt));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
`ifndef LOADER_CHECKSUM_EN
        if (ok) begin
            check("done_latency", 32'(done_cyc - last_acc_cyc), (n == 0) ? 32'd2 : 32'd3);
            if (n != 0) check("release_after_write", 32'(done_cyc - last_we_cyc), 32'd2);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        words_q = '{32'h2008_0005, 32'h0000_000C};
        do_load(32'd2, ck_for(32'd2), 1'b0);
        check("t1_words_loaded", 32'(words_loaded), 32'd2);
        check("t1_done", {31'd0, done}, 32'd1);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("run_ignores_in_ready", {31'd0, in_ready}, 32'd0);
        check("run_ignores_count", 32'(words_loaded), 32'd2);

        do_reset();
        words_q.delete();
        do_load(32'd0, 32'd0, 1'b0);
        check("t2_words_loaded", 32'(words_loaded), 32'd0);

        do_reset();
        words_q.delete();
        do_load(32'h0000_0101, 32'd0, 1'b0);
        check("t3_error", {31'd0, error}, 32'd1);
        check("t3_cpu_start_up", {31'd0, cpu_start_up}, 32'd1);

        do_reset();
        words_q = '{32'h0102_0304, 32'hA5A5_5A5A, 32'hFFFF_0000};
        do_load(32'd3, ck_for(32'd3), 1'b1);

        do_reset();
        words_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        exp_q.delete();
        send_word(32'd4, 1'b0, -1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("midload_words_loaded", 32'(words_loaded), 32'd0);
        do_reset();
        words_q = '{32'hDEAD_BEEF};
        do_load(32'd1, ck_for(32'd1), 1'b0);
        check("reload_done", {31'd0, done}, 32'd1);

        do_reset();
        words_q.delete();
        for (int i = 0; i < DEPTH; i++) words_q.push_back(32'h0101_0101 * 32'(i) ^ 32'h5A00_00A5);
        do_load(32'(DEPTH), ck_for(32'(DEPTH)), 1'b0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        words_q = '{32'h0000_0010};
        do_load(32'd1, 32'hFFFF_FFEF, 1'b0);
        check("ck_good_done", {31'd0, done}, 32'd1);
        do_reset();
        do_load(32'd1, 32'hFFFF_FFF0, 1'b0);
        check("ck_bad_error", {31'd0, error}, 32'd1);
        check("ck_bad_start_up", {31'd0, cpu_start_up}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory. It is the write side of the fetch interface, which on its own only ever reads.
- Accepts a byte stream over a valid/ready handshake: first a word-count header, then program words.
- Packs each four bytes into a 32-bit word and writes it to the instruction-memory write port.
- Holds the processor in start-up (PC reset) until the image is fully written, then releases it.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, max program words accepted (must be <= 2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  word to write
cpu_start_up  output  1  drives processor start_up; high = hold PC in reset
done  output  1  load complete, processor running
error  output  1  sticky load failure
words_loaded  output  ADDR_W+1  count of program words written

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=HDR, in_ready=0 during reset then 1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_start_up=1, done=0, error=0, words_loaded=0, byte counter=0.
- Handshake: a byte transfers on a clk edge with in_valid&&in_ready. in_ready=1 only in HDR and LOAD.
- Byte order: big-endian. 1st byte goes to [31:24], 4th byte to [7:0]. Partial words are held across in_valid gaps.
- States:
  - HDR: collect 4 bytes giving N.
    - N==0 -> RELEASE.
    - N>DEPTH -> ERR.
    - Otherwise -> LOAD.
  - LOAD: on each 4th byte accepted at cycle t, at t+1 imem_we=1, imem_addr=word index (0..N-1), imem_wdata=word, and words_loaded increments.
    - After word N-1 is accepted -> RELEASE (or CHK when the optional feature is compiled in).
    - in_ready stays 1 during the write pulse; there is no stall.
  - RELEASE: one cycle, entered at t+2 relative to the final byte. cpu_start_up=1 and imem_we=0, so memory is final before the PC leaves reset.
  - RUN: entered at t+3. cpu_start_up=0, done=1, in_ready=0. Terminal until reset; further bytes are ignored (not accepted).
  - ERR: in_ready=0, error=1, cpu_start_up=1, done=0. Terminal until reset.
- imem_addr wraps never: index is bounded by N<=DEPTH.
- Reset mid-load: partial word discarded, counters cleared, processor held. Memory contents already written are not cleared.
- Simultaneous: the header's 4th byte and the first data byte cannot share a cycle (one byte per cycle). The write pulse of word k may coincide with acceptance of the first byte of word k+1; this is required to work.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN
- Defined:
  - After N data words, state CHK collects one extra 4-byte word.
  - If (N + sum of data words + checksum word) mod 2^32 == 0 -> RELEASE, else -> ERR.
  - For N==0 the checksum word is still required.
  - The checksum word is not written to memory.
- Undefined: no CHK state; LOAD goes directly to RELEASE.

Decomposition:
- Shared package/include loader_defs:
  - state encodings HDR/LOAD/CHK/RELEASE/RUN/ERR
  - WORD_BYTES=4
  - header field width
- One natural sub-module: byte_packer. It takes the valid/ready byte in and emits a one-cycle word_valid plus a 32-bit word, with a 2-bit byte counter and shift register.
- The top holds the FSM, address counter and checksum accumulator.

Test Plan:
- Stream 00 00 00 02, 20 08 00 05, 00 00 00 0C with no gaps -> imem_we pulses twice: addr0=0x20080005, addr1=0x0000000C. cpu_start_up falls 2 cycles after the 2nd write pulse; done=1; words_loaded=2.
- Header 0 -> no imem_we; cpu_start_up=0 and done=1 at 2 cycles after the header's last byte.
- Header 0x00000101 with DEPTH=256 -> error=1, in_ready=0, cpu_start_up stays 1, no writes.
- in_valid toggled randomly (about 50%) mid-word on a 3-word load -> words and addresses identical to the gap-free case.
- Assert rst_n low after 6 bytes of a 4-word load, then reload 1 word 0xDEADBEEF -> single write addr0=0xDEADBEEF, done=1, no stale partial word.
- With LOADER_CHECKSUM_EN: N=1, word 0x00000010, checksum 0xFFFFFFEF -> done=1. Same stream with checksum 0xFFFFFFF0 -> error=1 and cpu_start_up held at 1.
